// File: rtl/noc_link_credit_stage.sv
`timescale 1ns/1ps
// Registered credit-based NoC link retiming stage: flit FIFO plus independent downstream credit counter.
// Latency 2 edges from send_in to send_out when empty with credit; pops stall while downstream credits are 0.
module noc_link_credit_stage #(
    parameter int FLIT_WIDTH         = 32,
    parameter int DEST_WIDTH         = 6,
    parameter int BUFFER_DEPTH       = 4,
    parameter int DOWNSTREAM_CREDITS = 2,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic                  overflow_err,
    output logic                  credit_err,
    output logic [CNT_WIDTH-1:0]  flit_count,
    output logic [CNT_WIDTH-1:0]  pkt_count
);
    localparam int PTR_W = (BUFFER_DEPTH > 2) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);
    localparam int CRD_W = (DOWNSTREAM_CREDITS > 1) ? $clog2(DOWNSTREAM_CREDITS + 1) : 1;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    flit_t                 r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic [CRD_W-1:0]      r_credit_cnt;
    flit_t                 r_out;
    logic                  r_send_out;
    logic                  r_credit_out;
    logic                  r_overflow_err;
    logic                  r_credit_err;
    logic [CNT_WIDTH-1:0]  r_flit_count;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    flit_t                 w_in_flit;
    flit_t                 w_head;

    // Reset asserts asynchronously but releases only on a clk_noc edge.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_full    = (r_occ == OCC_W'(BUFFER_DEPTH));
    assign w_pop     = (r_occ != '0) && (r_credit_cnt != '0);
    assign w_push    = send_in && (!w_full || w_pop);
    assign w_in_flit = '{data: data_in, dest: dest_in, tail: is_tail_in};
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk_noc) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_flit;
    end

    always_ff @(posedge clk_noc or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_occ          <= '0;
            r_credit_cnt   <= CRD_W'(DOWNSTREAM_CREDITS);
            r_out          <= '0;
            r_send_out     <= 1'b0;
            r_credit_out   <= 1'b0;
            r_overflow_err <= 1'b0;
            r_credit_err   <= 1'b0;
            r_flit_count   <= '0;
            r_pkt_count    <= '0;
        end else begin
            r_send_out   <= w_pop;
            r_credit_out <= w_pop;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= (r_rd_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
                r_out        <= w_head;
                r_flit_count <= r_flit_count + CNT_WIDTH'(1);
                if (w_head.tail) r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: ;
            endcase
            if (send_in && w_full && !w_pop) r_overflow_err <= 1'b1;
            // A same-cycle pop and return cancel out, so only a lone return can overshoot.
            case ({w_pop, credit_in})
                2'b10:   r_credit_cnt <= r_credit_cnt - CRD_W'(1);
                2'b01: begin
                    if (r_credit_cnt == CRD_W'(DOWNSTREAM_CREDITS)) r_credit_err <= 1'b1;
                    else                                            r_credit_cnt <= r_credit_cnt + CRD_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign data_out     = r_out.data;
    assign dest_out     = r_out.dest;
    assign is_tail_out  = r_out.tail;
    assign send_out     = r_send_out;
    assign credit_out   = r_credit_out;
    assign overflow_err = r_overflow_err;
    assign credit_err   = r_credit_err;
    assign flit_count   = r_flit_count;
    assign pkt_count    = r_pkt_count;
endmodule
